// File: rtl/beep_tone_gen.sv
// beep_tone_gen: multi-key debounced buzzer driver with hold, one-shot and double-beep modes
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   key_in   raw active-low keys, asynchronous to clk
//   mode     0 hold, 1 one-shot, 2 double, 3 mute
//   beep_out buzzer square wave
//   busy     high whenever the FSM is not IDLE
//   key_idx  index of the sounding key, held in IDLE
// Optional feature: define BEEP_DEBOUNCE_EN to insert a per-key DEB_CNT-cycle debouncer.
module beep_tone_gen #(
   parameter int KEY_NUM   = 4,
   parameter int DIV_W     = 20,
   parameter int BASE_HALF = 25000,
   parameter int STEP_HALF = 5000,
   parameter int DEB_CNT   = 1000000,
   parameter int BEEP_LEN  = 25000000,
   parameter int GAP_LEN   = 12500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] key_in,
   input  logic [1:0]         mode,
   output logic               beep_out,
   output logic               busy,
   output logic [2:0]         key_idx
);
   typedef enum logic [1:0] {IDLE, TONE1, GAP, TONE2} state_t;
   localparam logic [31:0] BEEP_LAST = 32'(BEEP_LEN - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_LEN - 1);
   if (KEY_NUM < 1 || KEY_NUM > 8 || DEB_CNT < 1 || BEEP_LEN < 1 || GAP_LEN < 1) begin : g_bad_param
      $error("beep_tone_gen: parameter out of range");
   end
   logic [KEY_NUM-1:0] sync1_q, sync2_q, db_lvl, kd_q, kd_prev_q, arm_q, ev;
   logic               v1_q;
   // A key only becomes armed once it has been seen released after reset, so a
   // key held through reset cannot fire until it is released and pressed again.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         kd_q      <= '1;
         kd_prev_q <= '1;
         arm_q     <= '0;
         v1_q      <= 1'b0;
      end else begin
         sync1_q   <= key_in;
         sync2_q   <= sync1_q;
         kd_q      <= db_lvl;
         kd_prev_q <= kd_q;
         v1_q      <= 1'b1;
         arm_q     <= arm_q | (sync1_q & {KEY_NUM{v1_q}});
      end
   end
`ifdef BEEP_DEBOUNCE_EN
   localparam logic [31:0] DEB_LAST = 32'(DEB_CNT - 1);
   logic [KEY_NUM-1:0] db_q;
   logic [31:0]        db_cnt_q [KEY_NUM];
   always_ff @(posedge clk) begin
      if (rst) begin
         db_q <= '1;
         for (int i = 0; i < KEY_NUM; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < KEY_NUM; i++) begin
            if (sync2_q[i] == db_q[i]) db_cnt_q[i] <= '0;
            else if (db_cnt_q[i] == DEB_LAST) begin
               db_q[i]     <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else db_cnt_q[i] <= db_cnt_q[i] + 32'd1;
         end
      end
   end
   assign db_lvl = db_q;
`else
   assign db_lvl = sync2_q;
`endif
   assign ev = kd_prev_q & ~kd_q & arm_q;
   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [2:0]        key_idx_q, key_idx_d, ev_idx;
   logic [31:0]       dur_q, dur_d, half_full;
   logic [DIV_W-1:0]  half_q, half_d, half_last;
   logic              beep_q, beep_d, busy_q, busy_d, enter, tone, wrap;
   logic [7:0]        kd_pad;
   always_comb begin
      ev_idx = '0;
      for (int i = KEY_NUM - 1; i >= 0; i--) if (ev[i]) ev_idx = 3'(i);
      kd_pad = '1;
      kd_pad[KEY_NUM-1:0] = kd_q;
   end
   assign half_full = 32'(BASE_HALF) + 32'(STEP_HALF) * {29'd0, key_idx_q};
   assign half_last = DIV_W'(half_full - 32'd1);
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      key_idx_d = key_idx_q;
      enter     = 1'b0;
      if (mode == 2'd3) state_d = IDLE;
      else if (|ev) begin
         state_d   = TONE1;
         mode_d    = mode;
         key_idx_d = ev_idx;
         enter     = 1'b1;
      end else begin
         case (state_q)
            TONE1:
               if (mode_q == 2'd0) state_d = kd_pad[key_idx_q] ? IDLE : TONE1;
               else if (dur_q == BEEP_LAST) state_d = (mode_q == 2'd2) ? GAP : IDLE;
            GAP:     if (dur_q == GAP_LAST) state_d = TONE2;
            TONE2:   if (dur_q == BEEP_LAST) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      enter  = enter | (state_d != state_q);
      tone   = (state_d == TONE1) || (state_d == TONE2);
      wrap   = half_q == half_last;
      dur_d  = (enter || state_d == IDLE) ? '0 : dur_q + 32'd1;
      half_d = (!tone || enter || wrap) ? '0 : half_q + 1'b1;
      beep_d = !tone ? 1'b0 : enter ? 1'b1 : (beep_q ^ wrap);
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= '0;
         key_idx_q <= '0;
         dur_q     <= '0;
         half_q    <= '0;
         beep_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         key_idx_q <= key_idx_d;
         dur_q     <= dur_d;
         half_q    <= half_d;
         beep_q    <= beep_d;
         busy_q    <= busy_d;
      end
   end
   assign beep_out = beep_q;
   assign busy     = busy_q;
   assign key_idx  = key_idx_q;
endmodule

// File: tb/tb_beep_tone_gen.sv
// tb_beep_tone_gen: scoreboard bench timing every output change of beep_tone_gen
module tb_beep_tone_gen;
`ifdef BEEP_DEBOUNCE_EN
   localparam int LAT = 11;
`else
   localparam int LAT = 3;
`endif
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_in;
   logic [1:0] mode;
   logic       beep_out, busy;
   logic [2:0] key_idx;
   beep_tone_gen #(
      .KEY_NUM(4), .DIV_W(20), .BASE_HALF(10), .STEP_HALF(5),
      .DEB_CNT(8), .BEEP_LEN(100), .GAP_LEN(50)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .mode(mode),
      .beep_out(beep_out), .busy(busy), .key_idx(key_idx)
   );
   initial forever #5 clk = ~clk;
   typedef struct {int cyc; logic [4:0] val;} exp_t;
   exp_t       sbq[$];
   int         cyc = 0, n_tests = 0, n_fail = 0, n, e;
   logic       mon_en = 1'b0;
   logic [4:0] prev, cur;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic push(input int c, input logic b, input logic o, input logic [2:0] k);
      exp_t x;
      x.cyc = c;
      x.val = {b, o, k};
      sbq.push_back(x);
   endtask
   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {busy, beep_out, key_idx};
         if (cur !== prev) begin
            if (sbq.size() == 0) chk("sb_unexpected", 32'(cur), 32'(prev));
            else begin
               exp_t x;
               x = sbq.pop_front();
               chk("ev_cycle", 32'(cyc), 32'(x.cyc));
               chk("ev_value", 32'(cur), 32'(x.val));
            end
            prev = cur;
         end
      end
   end
   initial begin
      rst = 1'b1;
      key_in = '1;
      mode = 2'd0;
      tick(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_beep", 32'(beep_out), 0);
      chk("rst_idx", 32'(key_idx), 0);
      rst = 1'b0;
      prev = '0;
      mon_en = 1'b1;
      tick(20);
      // hold, key 1, half 15
      n = cyc + 1; e = n + LAT;
      key_in[1] = 1'b0;
      push(e, 1, 1, 3'd1);
      for (int j = 1; j <= 19; j++) push(e + 15 * j, 1, (j % 2) == 0, 3'd1);
      tick(300);
      key_in[1] = 1'b1;
      push(cyc + 1 + LAT, 0, 0, 3'd1);
      tick(40);
      // bounce on key 0
`ifndef BEEP_DEBOUNCE_EN
      mode = 2'd3;
`endif
      key_in[0] = 1'b0;
      repeat (14) begin
         tick(3);
         key_in[0] = ~key_in[0];
      end
      key_in[0] = 1'b1;
      tick(30);
      chk("bounce_busy", 32'(busy), 0);
      chk("bounce_beep", 32'(beep_out), 0);
      // one-shot, key 2, half 20
      mode = 2'd1;
      n = cyc + 1; e = n + LAT;
      key_in[2] = 1'b0;
      push(e, 1, 1, 3'd2);
      for (int j = 1; j <= 4; j++) push(e + 20 * j, 1, (j % 2) == 0, 3'd2);
      push(e + 100, 0, 0, 3'd2);
      tick(500);
      chk("oneshot_held_busy", 32'(busy), 0);
      key_in[2] = 1'b1;
      tick(30);
      // double, key 3, half 25
      mode = 2'd2;
      n = cyc + 1; e = n + LAT;
      key_in[3] = 1'b0;
      push(e, 1, 1, 3'd3);
      for (int j = 1; j <= 3; j++) push(e + 25 * j, 1, (j % 2) == 0, 3'd3);
      for (int j = 0; j <= 3; j++) push(e + 150 + 25 * j, 1, (j % 2) == 0, 3'd3);
      push(e + 250, 0, 0, 3'd3);
      tick(20);
      key_in[3] = 1'b1;
      tick(e + 125 - cyc);
      chk("gap_busy", 32'(busy), 1);
      chk("gap_beep", 32'(beep_out), 0);
      tick(200);
      // priority (keys 2 and 0 together) then retrigger by key 3
      mode = 2'd1;
      n = cyc + 1; e = n + LAT;
      key_in[0] = 1'b0;
      key_in[2] = 1'b0;
      push(e, 1, 1, 3'd0);
      for (int j = 1; j <= 3; j++) push(e + 10 * j, 1, (j % 2) == 0, 3'd0);
      push(e + 40, 1, 1, 3'd3);
      for (int j = 1; j <= 3; j++) push(e + 40 + 25 * j, 1, (j % 2) == 0, 3'd3);
      push(e + 140, 0, 0, 3'd3);
      tick(40);
      key_in[3] = 1'b0;
      tick(150);
      key_in = '1;
      tick(30);
      // mute mid-tone
      mode = 2'd0;
      n = cyc + 1; e = n + LAT;
      key_in[1] = 1'b0;
      push(e, 1, 1, 3'd1);
      tick(e + 4 - cyc);
      mode = 2'd3;
      push(e + 5, 0, 0, 3'd1);
      tick(1);
      chk("mute_busy", 32'(busy), 0);
      chk("mute_beep", 32'(beep_out), 0);
      tick(20);
      key_in[1] = 1'b1;
      tick(30);
      mode = 2'd0;
      // reset mid double-beep, key 0 held through reset
      mode = 2'd2;
      n = cyc + 1; e = n + LAT;
      key_in[0] = 1'b0;
      push(e, 1, 1, 3'd0);
      push(e + 10, 1, 0, 3'd0);
      push(e + 20, 1, 1, 3'd0);
      tick(e + 25 - cyc);
      rst = 1'b1;
      push(e + 26, 0, 0, 3'd0);
      tick(1);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_beep", 32'(beep_out), 0);
      chk("midrst_idx", 32'(key_idx), 0);
      tick(1);
      rst = 1'b0;
      tick(40);
      chk("held_thru_rst_busy", 32'(busy), 0);
      key_in[0] = 1'b1;
      tick(30);
      // fresh press after reset works again
      mode = 2'd1;
      n = cyc + 1; e = n + LAT;
      key_in[0] = 1'b0;
      push(e, 1, 1, 3'd0);
      for (int j = 1; j <= 9; j++) push(e + 10 * j, 1, (j % 2) == 0, 3'd0);
      push(e + 100, 0, 0, 3'd0);
      tick(130);
      key_in[0] = 1'b1;
      tick(30);
      chk("sb_left", 32'(sbq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
